memtest_seq: RTL and testbench
==============================

MEMTEST_SEQ -- requirements
Module: memtest_seq

Interface
REQ-001 The block SHALL provide these parameters:
- ADDR_W, 24, word-address width.
- DATA_W, 16, data width.
- BASE, 0, first word address tested.
- DEPTH, 21, number of words tested, minimum 1.
- ACC_CYCLES, 8, cycles each strobe is held, minimum 2.
- ERR_W, 16, error-counter width.
REQ-002 The block SHALL provide these ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin a run; sampled only in IDLE or DONE.
- mode  in  2  pattern select: 0 addr+1, 1 ~(addr+1), 2 walking-one, 3 LFSR.
- continuous  in  1  repeat passes until deasserted.
- mem_addr  out  ADDR_W  word address to the SDRAM controller.
- mem_din  out  DATA_W  write data to the controller.
- mem_dout  in  DATA_W  read data from the controller.
- mem_as  out  1  address strobe, active high.
- mem_ds  out  2  byte data strobes, active high.
- mem_rw  out  1  1 = read, 0 = write.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at the end of every pass.
- pass_ok  out  1  err_count == 0 at the last done.
- err_count  out  ERR_W  mismatches since start; saturating.
- first_err_addr  out  ADDR_W  address of the first mismatch.
- first_err_exp  out  DATA_W  expected data at the first mismatch.
- first_err_got  out  DATA_W  read data at the first mismatch.
- pass_count  out  8  completed passes since start; wraps.

Function
REQ-003 States SHALL be IDLE, WRITE, WGAP, READ, RGAP, CHECK, DONE.
REQ-004 IDLE/DONE + start SHALL latch mode, clear err_count/pass_count/first_err_*, set index i=0, and enter WRITE.
- mem_as rises in the cycle after start is sampled.
REQ-005 Every access SHALL hold mem_as=1, mem_ds=2'b11, and stable mem_addr, mem_rw and mem_din for exactly ACC_CYCLES cycles.
- The access is then followed by exactly one gap cycle (WGAP/RGAP) with mem_as=0 and mem_ds=0.
REQ-006 mem_addr SHALL equal (BASE + i) mod 2^ADDR_W.
REQ-007 Pattern p(i) SHALL be:
- mode 0: (i+1) mod 2^DATA_W.
- mode 1: bitwise inverse of mode 0.
- mode 2: 1 << (i mod DATA_W).
- mode 3 (DATA_W=16): Fibonacci LFSR, seed 16'h0001, shift left, feedback b15^b14^b12^b3, advanced once per word; for DATA_W != 16, mode 3 SHALL behave as mode 0.
REQ-008 WRITE SHALL run i=0..DEPTH-1 with mem_rw=0 and mem_din=p(i); after word DEPTH-1's gap, i=0, LFSR reseeded, enter READ.
REQ-009 READ SHALL use mem_rw=1, drive mem_din=0, and sample mem_dout on the last strobe cycle of each access; the comparison against p(i) occurs in RGAP.
REQ-010 On a mismatch, err_count SHALL increment, saturating at all ones.
- If err_count was 0 before this increment, the addr, expected and read data SHALL be captured into first_err_*.
REQ-011 After word DEPTH-1's compare, CHECK SHALL last one cycle, assert done, and increment pass_count.
- Then: if continuous=1, enter WRITE with i=0, errors kept; else enter DONE.
REQ-012 Deasserting continuous mid-pass SHALL finish the current pass, then enter DONE.
REQ-013 busy SHALL be 1 in every state except IDLE and DONE.
REQ-014 pass_ok SHALL update only on done.
REQ-015 start SHALL be ignored while busy; mode changes SHALL be ignored while busy.
REQ-016 DEPTH=1 SHALL give exactly one write and one read per pass.

Reset
REQ-017 Reset SHALL win over start and over any state, and SHALL force IDLE on the next edge.
REQ-018 Reset SHALL zero all outputs, i and pass_count; the LFSR SHALL go to its seed.
REQ-019 Reset asserted mid-access SHALL drop mem_as and mem_ds on the following edge with no further accesses.

Verification
REQ-020 Pass/fail SHALL be covered by these directed scenarios:
- Zero-latency memory model, DEPTH=21, mode 0, start -> 21 writes of data 1..21 to addresses 0..20, 21 reads, done pulse, pass_ok=1, err_count=0, pass_count=1.
- Model corrupts addr 5 to 16'h0000, mode 1 -> err_count=1, first_err_addr=5, first_err_exp=16'hFFF9, first_err_got=16'h0000, pass_ok=0.
- ACC_CYCLES=4, mode 2 -> each mem_as pulse exactly 4 cycles high then 1 cycle low; word 17 data 16'h0002; BASE=2^24-2 wraps address to 0 on the third word.
- continuous=1 for 3 passes, then deassert mid-pass 4 -> four done pulses, pass_count=4, final state DONE, busy=0.
- Reset asserted during the 3rd write strobe with start held high -> next edge mem_as=0, busy=0, all counters 0, no access until reset is released and start is sampled.
- Model always returns 16'h1234 with ERR_W=2 -> err_count saturates at 3; first_err_* unchanged after the first mismatch.

Source files
------------

// File: rtl/memtest_seq_if.sv
// Memory-side bus between memtest_seq (master) and the SDRAM controller (slave).
interface memtest_seq_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;
    logic              mem_as;
    logic [1:0]        mem_ds;
    logic              mem_rw;

    modport master (
        output mem_addr, mem_din, mem_as, mem_ds, mem_rw,
        input  mem_dout
    );

    modport slave (
        input  mem_addr, mem_din, mem_as, mem_ds, mem_rw,
        output mem_dout
    );
endinterface

// File: rtl/memtest_seq.sv
// Write-then-read memory test sequencer: fills DEPTH words with a selectable
// pattern, reads them back, counts mismatches and records the first one.
//   state | meaning
//   IDLE  | waiting for start after reset
//   WRITE | write strobe held for ACC_CYCLES
//   WGAP  | one idle cycle after each write
//   READ  | read strobe held for ACC_CYCLES, data sampled on the last cycle
//   RGAP  | one idle cycle after each read, compare happens here
//   CHECK | end of pass, done pulse
//   DONE  | run finished, waiting for start
module memtest_seq #(
    parameter int          ADDR_W     = 24,
    parameter int          DATA_W     = 16,
    parameter int unsigned BASE       = 0,
    parameter int          DEPTH      = 21,
    parameter int          ACC_CYCLES = 8,
    parameter int          ERR_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              continuous,
    memtest_seq_if.master     mem,
    output logic              busy,
    output logic              done,
    output logic              pass_ok,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_exp,
    output logic [DATA_W-1:0] first_err_got,
    output logic [7:0]        pass_count
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TMR_W = $clog2(ACC_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(ACC_CYCLES - 1);
    localparam logic [15:0]      LFSR_SEED = 16'h0001;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WGAP,
        READ,
        RGAP,
        CHECK,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [IDX_W-1:0]  idx;
    logic [TMR_W-1:0]  tmr;
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] seq_pat;
    logic [DATA_W-1:0] walk_pat;
    logic [15:0]       lfsr;
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] pattern;
    logic [ADDR_W-1:0] addr_cur;

    logic load_tmr;
    logic restart_pat;
    logic adv_word;
    logic begin_run;
    logic strobe;
    logic tmr_zero;
    logic last_word;
    logic mismatch;
    logic err_sat;

    assign tmr_zero  = (tmr == '0);
    assign last_word = (idx == LAST_IDX);
    assign strobe    = (state == WRITE) || (state == READ);
    assign begin_run = ((state == IDLE) || (state == DONE)) && start;
    assign mismatch  = (rd_q != pattern);
    assign err_sat   = &err_count;
    assign addr_cur  = ADDR_W'(BASE) + ADDR_W'(idx);

    // Pattern generators advance per word so no divider or shifter by i is needed.
    always_comb begin
        case (mode_q)
            2'd1:    pattern = ~seq_pat;
            2'd2:    pattern = walk_pat;
            2'd3:    pattern = (DATA_W == 16) ? DATA_W'(lfsr) : seq_pat;
            default: pattern = seq_pat;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        load_tmr    = 1'b0;
        restart_pat = 1'b0;
        adv_word    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    next_state  = WRITE;
                    load_tmr    = 1'b1;
                    restart_pat = 1'b1;
                end
            end
            WRITE: begin
                if (tmr_zero) begin
                    next_state = WGAP;
                end
            end
            WGAP: begin
                load_tmr = 1'b1;
                if (last_word) begin
                    next_state  = READ;
                    restart_pat = 1'b1;
                end else begin
                    next_state = WRITE;
                    adv_word   = 1'b1;
                end
            end
            READ: begin
                if (tmr_zero) begin
                    next_state = RGAP;
                end
            end
            RGAP: begin
                if (last_word) begin
                    next_state = CHECK;
                end else begin
                    next_state = READ;
                    adv_word   = 1'b1;
                    load_tmr   = 1'b1;
                end
            end
            CHECK: begin
                if (continuous) begin
                    next_state  = WRITE;
                    restart_pat = 1'b1;
                    load_tmr    = 1'b1;
                end else begin
                    next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign mem.mem_as   = strobe;
    assign mem.mem_ds   = {2{strobe}};
    assign mem.mem_rw   = (state == READ) || (state == RGAP);
    assign mem.mem_addr = (state inside {WRITE, WGAP, READ, RGAP}) ? addr_cur : '0;
    assign mem.mem_din  = (state inside {WRITE, WGAP}) ? pattern : '0;

    assign busy = (state != IDLE) && (state != DONE);
    assign done = (state == CHECK);

    always_ff @(posedge clk) begin
        if (reset) begin
            idx            <= '0;
            tmr            <= '0;
            mode_q         <= '0;
            seq_pat        <= DATA_W'(1);
            walk_pat       <= DATA_W'(1);
            lfsr           <= LFSR_SEED;
            rd_q           <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_exp  <= '0;
            first_err_got  <= '0;
            pass_count     <= '0;
            pass_ok        <= 1'b0;
        end else begin
            if (begin_run) begin
                mode_q         <= mode;
                err_count      <= '0;
                first_err_addr <= '0;
                first_err_exp  <= '0;
                first_err_got  <= '0;
                pass_count     <= '0;
            end

            if (load_tmr) begin
                tmr <= TMR_LOAD;
            end else if (strobe && !tmr_zero) begin
                tmr <= tmr - 1'b1;
            end

            if (restart_pat) begin
                idx      <= '0;
                seq_pat  <= DATA_W'(1);
                walk_pat <= DATA_W'(1);
                lfsr     <= LFSR_SEED;
            end else if (adv_word) begin
                idx      <= idx + 1'b1;
                seq_pat  <= seq_pat + 1'b1;
                walk_pat <= {walk_pat[DATA_W-2:0], walk_pat[DATA_W-1]};
                lfsr     <= {lfsr[14:0], lfsr[15] ^ lfsr[14] ^ lfsr[12] ^ lfsr[3]};
            end

            if ((state == READ) && tmr_zero) begin
                rd_q <= mem.mem_dout;
            end

            // pass_ok and pass_count settle on entry to CHECK so they are valid alongside done.
            if (state == RGAP) begin
                if (mismatch) begin
                    if (!err_sat) begin
                        err_count <= err_count + 1'b1;
                    end
                    if (err_count == '0) begin
                        first_err_addr <= addr_cur;
                        first_err_exp  <= pattern;
                        first_err_got  <= rd_q;
                    end
                end
                if (last_word) begin
                    pass_count <= pass_count + 1'b1;
                    pass_ok    <= (err_count == '0) && !mismatch;
                end
            end
        end
    end

endmodule

// File: tb/tb_memtest_seq.sv
// Bench for memtest_seq: three parameter sets share one stimulus stream and are
// checked each cycle against a pass-timeline model built from word/slot arithmetic.
module tb_memtest_seq;

    localparam int NDUT = 3;

    function automatic int depth_of(input int k);
        return (k == 2) ? 1 : 21;
    endfunction

    function automatic int acc_of(input int k);
        case (k)
            0:       return 8;
            1:       return 4;
            default: return 2;
        endcase
    endfunction

    function automatic int unsigned base_of(input int k);
        case (k)
            0:       return 0;
            1:       return 32'h00FF_FFFE;
            default: return 5;
        endcase
    endfunction

    function automatic int errw_of(input int k);
        return (k == 1) ? 2 : 16;
    endfunction

    function automatic logic [23:0] addr_of(input int k, input int w);
        return 24'(base_of(k) + 32'(w));
    endfunction

    function automatic logic [15:0] pat(input logic [1:0] m, input int w);
        logic [15:0] l;
        l = 16'h0001;
        case (m)
            2'd0: return 16'(w + 1);
            2'd1: return ~16'(w + 1);
            2'd2: return 16'd1 << (w % 16);
            default: begin
                for (int n = 0; n < w; n++) l = {l[14:0], l[15] ^ l[14] ^ l[12] ^ l[3]};
                return l;
            end
        endcase
    endfunction

    logic        clk;
    logic        reset, start, continuous, stuck, corrupt_en, chk_en;
    logic [1:0]  mode;
    logic [23:0] corrupt_addr;
    int          n_checks = 0;
    int          n_fail = 0;

    logic        busy_o [NDUT];
    logic        done_o [NDUT];
    logic        pass_ok_o [NDUT];
    logic        as_o [NDUT];
    logic        rw_o [NDUT];
    logic [1:0]  ds_o [NDUT];
    logic [23:0] addr_o [NDUT];
    logic [23:0] fa_o [NDUT];
    logic [15:0] din_o [NDUT];
    logic [15:0] fe_o [NDUT];
    logic [15:0] fg_o [NDUT];
    logic [15:0] err_o [NDUT];
    logic [7:0]  pc_o [NDUT];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int EW = errw_of(g);
        logic [EW-1:0] errc;
        logic [15:0]   store [64];

        memtest_seq_if #(.ADDR_W(24), .DATA_W(16)) bus ();

        memtest_seq #(
            .ADDR_W(24), .DATA_W(16), .BASE(base_of(g)), .DEPTH(depth_of(g)),
            .ACC_CYCLES(acc_of(g)), .ERR_W(EW)
        ) dut (
            .clk(clk), .reset(reset), .start(start), .mode(mode), .continuous(continuous),
            .mem(bus.master), .busy(busy_o[g]), .done(done_o[g]), .pass_ok(pass_ok_o[g]),
            .err_count(errc), .first_err_addr(fa_o[g]), .first_err_exp(fe_o[g]),
            .first_err_got(fg_o[g]), .pass_count(pc_o[g])
        );

        assign err_o[g]  = 16'(errc);
        assign as_o[g]   = bus.mem_as;
        assign rw_o[g]   = bus.mem_rw;
        assign ds_o[g]   = bus.mem_ds;
        assign addr_o[g] = bus.mem_addr;
        assign din_o[g]  = bus.mem_din;

        // Zero-latency memory with injectable faults on the read path.
        always @(posedge clk) begin
            if (bus.mem_as && !bus.mem_rw) store[bus.mem_addr[5:0]] <= bus.mem_din;
        end
        assign bus.mem_dout = stuck ? 16'h1234 :
                              (corrupt_en && bus.mem_addr == corrupt_addr) ? 16'h0000 :
                              store[bus.mem_addr[5:0]];
    end

    task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h at %0t", name, k, got, exp, $time);
        end
    endtask

    // Model: per DUT, whether a run is active and the cycle number t within the pass.
    bit          m_run [NDUT];
    int          m_t [NDUT];
    logic [1:0]  m_md [NDUT];
    int          m_err [NDUT];
    logic [23:0] m_fa [NDUT];
    logic [15:0] m_fe [NDUT];
    logic [15:0] m_fg [NDUT];
    logic [7:0]  m_pc [NDUT];
    bit          m_pok [NDUT];

    always @(posedge clk) begin
        int d, l, u, w;
        logic [15:0] e, gt;
        logic [23:0] a;
        for (int k = 0; k < NDUT; k++) begin
            d = depth_of(k);
            l = acc_of(k) + 1;
            if (reset) begin
                m_run[k] = 0; m_t[k] = 0; m_md[k] = 2'd0; m_err[k] = 0;
                m_fa[k] = '0; m_fe[k] = '0; m_fg[k] = '0; m_pc[k] = '0; m_pok[k] = 0;
            end else if (!m_run[k]) begin
                if (start) begin
                    m_run[k] = 1; m_t[k] = 0; m_md[k] = mode; m_err[k] = 0;
                    m_fa[k] = '0; m_fe[k] = '0; m_fg[k] = '0; m_pc[k] = '0;
                end
            end else begin
                if (m_t[k] >= d * l && m_t[k] < 2 * d * l && ((m_t[k] - d * l) % l) == acc_of(k)) begin
                    u  = m_t[k] - d * l;
                    w  = u / l;
                    e  = pat(m_md[k], w);
                    a  = addr_of(k, w);
                    gt = stuck ? 16'h1234 : (corrupt_en && a == corrupt_addr) ? 16'h0000 : e;
                    if (gt != e) begin
                        if (m_err[k] == 0) begin
                            m_fa[k] = a; m_fe[k] = e; m_fg[k] = gt;
                        end
                        if (m_err[k] < (1 << errw_of(k)) - 1) m_err[k]++;
                    end
                    if (w == d - 1) begin
                        m_pc[k]  = m_pc[k] + 8'd1;
                        m_pok[k] = (m_err[k] == 0);
                    end
                end
                if (m_t[k] == 2 * d * l) begin
                    if (continuous) m_t[k] = 0;
                    else m_run[k] = 0;
                end else begin
                    m_t[k]++;
                end
            end
        end
    end

    always @(negedge clk) begin
        int d, l, w;
        bit stb, rd;
        if (chk_en) begin
            for (int k = 0; k < NDUT; k++) begin
                d   = depth_of(k);
                l   = acc_of(k) + 1;
                stb = m_run[k] && (m_t[k] < 2 * d * l) && ((m_t[k] % l) < acc_of(k));
                rd  = (m_t[k] >= d * l);
                w   = (m_t[k] % (d * l)) / l;
                chk("busy", k, 32'(busy_o[k]), 32'(m_run[k]));
                chk("done", k, 32'(done_o[k]), 32'(m_run[k] && m_t[k] == 2 * d * l));
                chk("mem_as", k, 32'(as_o[k]), 32'(stb));
                chk("mem_ds", k, 32'(ds_o[k]), stb ? 32'd3 : 32'd0);
                if (stb) begin
                    chk("mem_addr", k, 32'(addr_o[k]), 32'(addr_of(k, w)));
                    chk("mem_rw", k, 32'(rw_o[k]), 32'(rd));
                    chk("mem_din", k, 32'(din_o[k]), rd ? 32'd0 : 32'(pat(m_md[k], w)));
                end
                chk("err_count", k, 32'(err_o[k]), 32'(m_err[k]));
                chk("first_err_addr", k, 32'(fa_o[k]), 32'(m_fa[k]));
                chk("first_err_exp", k, 32'(fe_o[k]), 32'(m_fe[k]));
                chk("first_err_got", k, 32'(fg_o[k]), 32'(m_fg[k]));
                chk("pass_count", k, 32'(pc_o[k]), 32'(m_pc[k]));
                chk("pass_ok", k, 32'(pass_ok_o[k]), 32'(m_pok[k]));
            end
        end
    end

    task automatic pulse_start(input logic [1:0] m);
        mode  = m;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int n;
        n = 0;
        while ((busy_o[0] || busy_o[1] || busy_o[2]) && n < lim) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_checks++;
        if (n >= lim) begin
            n_fail++;
            $display("FAIL wait_idle: still busy after %0d cycles, required idle", lim);
        end
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; mode = 2'd0; continuous = 1'b0;
        stuck = 1'b0; corrupt_en = 1'b0; corrupt_addr = '0; chk_en = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            chk("rst_busy", k, 32'(busy_o[k]), 32'd0);
            chk("rst_as", k, 32'(as_o[k]), 32'd0);
            chk("rst_addr", k, 32'(addr_o[k]), 32'd0);
            chk("rst_err", k, 32'(err_o[k]), 32'd0);
            chk("rst_pc", k, 32'(pc_o[k]), 32'd0);
        end
        chk("model_p0_w20", 0, 32'(pat(2'd0, 20)), 32'h0015);
        chk("model_p1_w5", 0, 32'(pat(2'd1, 5)), 32'hFFF9);
        chk("model_p2_w17", 0, 32'(pat(2'd2, 17)), 32'h0002);
        chk("model_p3_w4", 0, 32'(pat(2'd3, 4)), 32'h0011);
        chk("model_wrap_w2", 1, 32'(addr_of(1, 2)), 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Single clean pass, counting pattern.
        pulse_start(2'd0);
        wait_idle(2000);
        @(negedge clk);
        chk("s1_pass_count", 0, 32'(pc_o[0]), 32'd1);
        chk("s1_pass_ok", 0, 32'(pass_ok_o[0]), 32'd1);
        chk("s1_err", 0, 32'(err_o[0]), 32'd0);
        chk("s1_pass_count_d1", 2, 32'(pc_o[2]), 32'd1);

        // Address 5 reads back as zero, inverted pattern.
        corrupt_addr = 24'd5;
        corrupt_en   = 1'b1;
        pulse_start(2'd1);
        wait_idle(2000);
        @(negedge clk);
        chk("s2_err", 0, 32'(err_o[0]), 32'd1);
        chk("s2_first_addr", 0, 32'(fa_o[0]), 32'd5);
        chk("s2_first_exp", 0, 32'(fe_o[0]), 32'hFFF9);
        chk("s2_first_got", 0, 32'(fg_o[0]), 32'h0000);
        chk("s2_pass_ok", 0, 32'(pass_ok_o[0]), 32'd0);
        corrupt_en = 1'b0;

        // Walking one; start and mode pokes mid-run must not disturb busy DUTs.
        pulse_start(2'd2);
        repeat (40) @(posedge clk);
        #1 mode = 2'd1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        mode = 2'd3;
        wait_idle(2000);
        @(negedge clk);
        chk("s3_pass_ok", 0, 32'(pass_ok_o[0]), 32'd1);
        chk("s3_pass_count", 0, 32'(pc_o[0]), 32'd1);

        // Continuous LFSR passes, released partway through pass 4.
        continuous = 1'b1;
        pulse_start(2'd3);
        n = 0;
        while (pc_o[0] != 8'd3 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("s4_reach_pass3", 0, 32'(n < 3000), 32'd1);
        repeat (100) @(posedge clk);
        #1 continuous = 1'b0;
        wait_idle(2000);
        @(negedge clk);
        chk("s4_pass_count", 0, 32'(pc_o[0]), 32'd4);
        chk("s4_busy", 0, 32'(busy_o[0]), 32'd0);
        chk("s4_pass_ok", 0, 32'(pass_ok_o[0]), 32'd1);

        // Reset during the third write strobe while start is held.
        mode  = 2'd0;
        start = 1'b1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        #1;
        chk("s5_in_strobe", 0, 32'(as_o[0]), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("s5_as", 0, 32'(as_o[0]), 32'd0);
        chk("s5_ds", 0, 32'(ds_o[0]), 32'd0);
        chk("s5_busy", 0, 32'(busy_o[0]), 32'd0);
        chk("s5_pass_count", 0, 32'(pc_o[0]), 32'd0);
        chk("s5_pass_ok", 0, 32'(pass_ok_o[0]), 32'd0);
        repeat (2) @(posedge clk);
        #1 start = 1'b0;
        reset = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("s5_idle_as", 0, 32'(as_o[0]), 32'd0);
        chk("s5_idle_busy", 0, 32'(busy_o[0]), 32'd0);

        // Memory stuck at 16'h1234: saturation on the 2-bit counter.
        stuck = 1'b1;
        pulse_start(2'd0);
        wait_idle(2000);
        @(negedge clk);
        chk("s6_err_sat", 1, 32'(err_o[1]), 32'd3);
        chk("s6_first_addr", 1, 32'(fa_o[1]), 32'h00FF_FFFE);
        chk("s6_first_exp", 1, 32'(fe_o[1]), 32'h0001);
        chk("s6_first_got", 1, 32'(fg_o[1]), 32'h1234);
        chk("s6_err_full", 0, 32'(err_o[0]), 32'd21);
        chk("s6_pass_ok", 0, 32'(pass_ok_o[0]), 32'd0);
        stuck = 1'b0;

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
